// File: rtl/dlc_ff_bank_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlc_ff_bank_pkg : shared types and helpers for the DL register bank       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package dlc_ff_bank_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } bank_st_e;

    // Index width for an n-entry selector; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dlc_ff_bank_arb_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlc_ff_bank_arb_if : requester / clear / readout bundle of the bank       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface dlc_ff_bank_arb_if #(
    parameter int REQS  = 4,
    parameter int SLOTS = 8,
    parameter int WIDTH = 32
);
    import dlc_ff_bank_pkg::*;

    localparam int AW = idx_width(SLOTS);

    logic [REQS-1:0]        req_valid;
    logic [REQS*AW-1:0]     req_addr;
    logic [REQS*WIDTH-1:0]  req_data;
    logic [REQS-1:0]        req_ack;
    logic                   addr_err;
    logic                   clr_start;
    logic                   clr_busy;
    logic                   clr_done;
    logic [SLOTS*WIDTH-1:0] slot_q;

    modport master (
        output req_valid, req_addr, req_data, clr_start,
        input  req_ack, addr_err, clr_busy, clr_done, slot_q
    );

    modport slave (
        input  req_valid, req_addr, req_data, clr_start,
        output req_ack, addr_err, clr_busy, clr_done, slot_q
    );

endinterface

`default_nettype wire

// File: rtl/dlc_ff_bank_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlc_ff_bank_rr_pick : combinational round-robin pick from a pointer       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dlc_ff_bank_rr_pick
    import dlc_ff_bank_pkg::*;
#(
    parameter int REQS = 4
) (
    input  wire logic [REQS-1:0]              elig_i,
    input  wire logic [idx_width(REQS)-1:0]   rr_ptr_i,
    output logic                              gnt_vld_o,
    output logic      [REQS-1:0]              gnt_o,
    output logic      [idx_width(REQS)-1:0]   gnt_idx_o
);

    localparam int IW = idx_width(REQS);

    int             w_pos;
    logic [IW-1:0]  w_idx;
    logic           w_found;

    // Scan upward from the pointer, wrapping; first eligible requester wins.
    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        w_found   = 1'b0;
        w_pos     = 0;
        w_idx     = '0;
        for (int i = 0; i < REQS; i++) begin
            w_pos = int'(rr_ptr_i) + i;
            if (w_pos >= REQS) begin
                w_pos = w_pos - REQS;
            end
            w_idx = IW'(w_pos);
            if (!w_found && elig_i[w_idx]) begin
                w_found        = 1'b1;
                gnt_vld_o      = 1'b1;
                gnt_o[w_idx]   = 1'b1;
                gnt_idx_o      = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dlc_ff_bank_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dlc_ff_bank_arb : round-robin write arbiter + clear sweep for a reg bank  |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module dlc_ff_bank_arb
    import dlc_ff_bank_pkg::*;
#(
    parameter int               REQS  = 4,
    parameter int               SLOTS = 8,
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] RSTV  = '0
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    dlc_ff_bank_arb_if.slave   bus
);

    localparam int AW = idx_width(SLOTS);
    localparam int IW = idx_width(REQS);

    bank_st_e           state_q, state_d;
    logic [AW-1:0]      clr_cnt_q, clr_cnt_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [REQS-1:0]    req_ack_q, req_ack_d;
    logic               addr_err_q, addr_err_d;
    logic               clr_done_q, clr_done_d;

    logic [REQS-1:0]    w_elig;
    logic               w_gnt_vld;
    logic [REQS-1:0]    w_gnt;
    logic [IW-1:0]      w_gnt_idx;
    logic [AW-1:0]      w_win_addr;
    logic [WIDTH-1:0]   w_win_data;
    logic [SLOTS-1:0]   w_hit;
    logic [SLOTS-1:0]   w_clr_sel;
    logic [SLOTS-1:0]   w_wr_en;
    logic [WIDTH-1:0]   w_wr_data;

    // A requester is masked in its ack cycle so a late-dropped valid cannot win twice.
    assign w_elig = bus.req_valid & ~req_ack_q;

    dlc_ff_bank_rr_pick #(
        .REQS (REQS)
    ) u_rr_pick (
        .elig_i    (w_elig),
        .rr_ptr_i  (rr_ptr_q),
        .gnt_vld_o (w_gnt_vld),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    always_comb begin
        w_win_addr = '0;
        w_win_data = '0;
        for (int r = 0; r < REQS; r++) begin
            if (w_gnt[r]) begin
                w_win_addr = bus.req_addr[r*AW +: AW];
                w_win_data = bus.req_data[r*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        req_ack_d  = '0;
        addr_err_d = 1'b0;
        clr_done_d = 1'b0;
        w_wr_en    = '0;
        w_wr_data  = w_win_data;
        case (state_q)
            ST_IDLE: begin
                if (bus.clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else if (w_gnt_vld) begin
                    // An address with no matching slot is acked but dropped.
                    w_wr_en    = w_hit;
                    req_ack_d  = w_gnt;
                    addr_err_d = ~|w_hit;
                    rr_ptr_d   = (w_gnt_idx == IW'(REQS-1)) ? '0 : w_gnt_idx + IW'(1);
                end
            end
            ST_CLEAR: begin
                w_wr_en   = w_clr_sel;
                w_wr_data = RSTV;
                if (clr_cnt_q == AW'(SLOTS-1)) begin
                    state_d    = ST_IDLE;
                    clr_cnt_d  = '0;
                    clr_done_d = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            rr_ptr_q   <= '0;
            req_ack_q  <= '0;
            addr_err_q <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            req_ack_q  <= req_ack_d;
            addr_err_q <= addr_err_d;
            clr_done_q <= clr_done_d;
        end
    end

    for (genvar s = 0; s < SLOTS; s++) begin : g_slot
        logic [WIDTH-1:0] data_q;

        assign w_hit[s]     = (w_win_addr == AW'(s));
        assign w_clr_sel[s] = (clr_cnt_q == AW'(s));

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                data_q <= RSTV;
            end else if (w_wr_en[s]) begin
                data_q <= w_wr_data;
            end
        end

        assign bus.slot_q[s*WIDTH +: WIDTH] = data_q;
    end

    assign bus.req_ack  = req_ack_q;
    assign bus.addr_err = addr_err_q;
    assign bus.clr_done = clr_done_q;
    assign bus.clr_busy = (state_q == ST_CLEAR);

endmodule

`default_nettype wire

// File: doc/dlc_ff_bank_arb.md
# dlc_ff_bank_arb

Round-robin write arbiter and sequencer for a bank of enable-gated configuration/spare registers in the DL. It shares `slots` registers of `width` bits among `reqs` requesters, accepting one write per cycle with a valid/ack handshake. It also provides a sequenced clear sweep that returns every slot to its reset value. All register contents are presented continuously to downstream DL logic.

## Interface
- `reqs`, default 4: number of requesters, ≥2.
- `slots`, default 8: number of registers in the bank, ≥2; need not be a power of 2.
- `width`, default 32: bits per slot.
- `rstv`, default 0: `width`-bit reset and clear value applied to every slot.
- `aw` (derived, not overridable): `$clog2(slots)`.

Ports:
- `clk` in 1: sole clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `reqs`: per-requester write request; held until acked.
- `req_addr` in `reqs*aw`: slot index, requester r at `[r*aw +: aw]`.
- `req_data` in `reqs*width`: write data, requester r at `[r*width +: width]`.
- `req_ack` out `reqs`: one-cycle pulse; the write of requester r is complete.
- `addr_err` out 1: pulses together with `req_ack` when the acked address is ≥ `slots`.
- `clr_start` in 1: pulse that requests a clear sweep.
- `clr_busy` out 1: high while the sweep runs.
- `clr_done` out 1: one-cycle pulse when the sweep completes.
- `slot_q` out `slots*width`: register contents, slot s at `[s*width +: width]`.

## Operation
- FSM states: IDLE and CLEAR.
- **IDLE**:
  - If `clr_start`=1, enter CLEAR with `clr_cnt`=0. No grant is issued this cycle; clear has priority over requests.
  - Otherwise, the eligible set is `req_valid & ~req_ack`. A requester is ineligible in its ack cycle, so no double write occurs if valid is dropped late.
  - Choose the winner round-robin, searching upward from `rr_ptr` and wrapping.
  - At the clock edge: write the winner's data to slot `addr` if `addr` < `slots`, otherwise drop the write. Set `req_ack[winner]` for the next cycle, set `addr_err` if the write was dropped, and set `rr_ptr` = (winner+1) mod `reqs`.
  - If no requester is eligible, `rr_ptr` is unchanged.
- **CLEAR**:
  - Each cycle, write `rstv` to slot `clr_cnt` and increment `clr_cnt`.
  - After the write to slot `slots-1`, return to IDLE and pulse `clr_done` in the following cycle.
  - `clr_start` is ignored while in CLEAR. No grants are issued; `req_valid` stays pending.
- Writes from different requesters never collide, since at most one write occurs per cycle.
- Reset (asynchronous, at any time, including mid-sweep):
  - all slots = `rstv`
  - state = IDLE, `clr_cnt`=0, `rr_ptr`=0
  - `req_ack`, `addr_err`, `clr_done`, `clr_busy` all 0
  - There is no partial-sweep resume.

## Timing
- Write latency is 1:
  - request is eligible and wins in cycle N;
  - `slot_q` shows the new data in cycle N+1;
  - `req_ack` pulses in cycle N+1.
- A requester holding `req_valid` continuously gets at most one grant every 2 cycles. Aggregate throughput is 1 write per cycle when ≥2 requesters are active.
- Worst-case grant wait with all requesters active is `reqs` cycles, excluding clear sweeps.
- Clear sweep timing, with `clr_start` sampled in IDLE cycle N:
  - `clr_busy`=1 in cycles N+1 … N+`slots`;
  - slot k reads `rstv` from cycle N+2+k;
  - `clr_done` pulses in cycle N+1+`slots`, together with the return to IDLE;
  - the first grant is possible in cycle N+1+`slots`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `dlc_ff_bank_pkg`:
  - state enum (`ST_IDLE`, `ST_CLEAR`);
  - helper function for the index width.
- Sub-module `dlc_ff_bank_rr_pick`: combinational, parameter `reqs`.
  - Inputs: eligible vector and `rr_ptr`.
  - Outputs: `gnt_vld`, one-hot `gnt`, binary `gnt_idx`.
- Slot storage is inline: `slots` × `width` enable-gated registers with asynchronous reset to `rstv`.

## Test plan
- **Reset value**: drive `reset_n`=0 at default parameters with `rstv`=0x0000_0000 → all `slot_q`=0, and `req_ack`, `addr_err`, `clr_busy`, `clr_done` all 0.
- **Single write**: requester 2 writes addr 5, data 0xDEAD_BEEF in cycle N → `slot_q[5]`=0xDEAD_BEEF and `req_ack`=4'b0100 in N+1; no other slot changes.
- **Round-robin fairness**: all 4 requesters hold `req_valid` with distinct addresses → ack order is 0,1,2,3,0,… at one ack per cycle; no requester is acked in consecutive cycles.
- **Clear priority**: `clr_start` and `req_valid[1]` in the same IDLE cycle N →
  - `clr_busy` high in N+1..N+8;
  - all slots equal `rstv` in N+9 (slot 7 from N+9, earlier slots progressively);
  - `clr_done` in N+9;
  - `req_ack[1]` in N+10, with that slot holding the new data.
- **Address error**: with `slots`=6, requester 0 writes addr 7 → `req_ack[0]` and `addr_err` pulse together; the bank is unchanged.
- **Reset mid-sweep**: assert `reset_n`=0 in cycle 3 of a sweep → `clr_busy` drops immediately; no `clr_done` pulse follows; the FSM is in IDLE after release.
